// File: rtl/guess_entry.sv
`default_nettype none
// ============================================================================
// Module      : guess_entry
// Description : Three-digit keypad guess editor with backspace/clear, and a
//               one-cycle commit strobe on Enter. Optional macro
//               GUESS_UNIQUE_CHECK_EN rejects commits with repeated digits.
// Revision    : 1.0 - initial release
// ============================================================================
module guess_entry #(
    parameter int HOLDOFF_CYC = 4,
    parameter int MAX_DIGIT   = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [3:0]  oNum1,
    output logic [3:0]  oNum2,
    output logic [3:0]  oNum3,
    output logic        oNumRdy,
    output logic [1:0]  oCount,
    output logic [11:0] oEdit,
    output logic        oErr
);

    localparam int c_HOLD_W = (HOLDOFF_CYC > 0) ? $clog2(HOLDOFF_CYC + 1) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(HOLDOFF_CYC);

    localparam logic [3:0] c_KEY_BS    = 4'hA;
    localparam logic [3:0] c_KEY_ENTER = 4'hB;
    localparam logic [3:0] c_KEY_CLEAR = 4'hC;

    localparam logic [1:0] S_ENTRY = 2'd0;
    localparam logic [1:0] S_FULL  = 2'd1;
    localparam logic [1:0] S_EMIT  = 2'd2;

    logic [1:0]          r_state;
    logic [c_HOLD_W-1:0] r_hold;
    logic [3:0]          r_d1, r_d2, r_d3;
    logic [1:0]          r_count;
    logic [3:0]          r_num1, r_num2, r_num3;
    logic                r_num_rdy;
    logic                r_err;

    logic w_accept;
    logic w_is_digit;
    logic w_dup;

    assign w_accept   = key_valid && (r_hold == '0) && (r_state != S_EMIT);
    assign w_is_digit = (key_code <= 4'd9) && (int'(key_code) <= MAX_DIGIT);

`ifdef GUESS_UNIQUE_CHECK_EN
    assign w_dup = (r_d1 == r_d2) || (r_d1 == r_d3) || (r_d2 == r_d3);
`else
    assign w_dup = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_ENTRY;
            r_hold    <= '0;
            r_d1      <= 4'h0;
            r_d2      <= 4'h0;
            r_d3      <= 4'h0;
            r_count   <= 2'd0;
            r_num1    <= 4'h0;
            r_num2    <= 4'h0;
            r_num3    <= 4'h0;
            r_num_rdy <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_num_rdy <= 1'b0;
            r_err     <= 1'b0;

            // Every accepted key, even an ignored code, restarts the chatter window.
            if (w_accept) begin
                r_hold <= c_HOLD_LOAD;
            end else if (r_hold != '0) begin
                r_hold <= r_hold - 1'b1;
            end

            case (r_state)
                S_ENTRY: begin
                    if (w_accept) begin
                        if (w_is_digit) begin
                            case (r_count)
                                2'd0:    r_d1 <= key_code;
                                2'd1:    r_d2 <= key_code;
                                default: r_d3 <= key_code;
                            endcase
                            r_count <= r_count + 2'd1;
                            if (r_count == 2'd2) begin
                                r_state <= S_FULL;
                            end
                        end else if (key_code == c_KEY_BS) begin
                            if (r_count != 2'd0) begin
                                case (r_count)
                                    2'd1:    r_d1 <= 4'h0;
                                    2'd2:    r_d2 <= 4'h0;
                                    default: r_d3 <= 4'h0;
                                endcase
                                r_count <= r_count - 2'd1;
                            end
                        end else if (key_code == c_KEY_CLEAR) begin
                            r_d1    <= 4'h0;
                            r_d2    <= 4'h0;
                            r_d3    <= 4'h0;
                            r_count <= 2'd0;
                        end else if (key_code == c_KEY_ENTER) begin
                            r_err <= 1'b1;
                        end
                    end
                end

                S_FULL: begin
                    if (w_accept) begin
                        if (key_code == c_KEY_BS) begin
                            r_d3    <= 4'h0;
                            r_count <= 2'd2;
                            r_state <= S_ENTRY;
                        end else if (key_code == c_KEY_CLEAR) begin
                            r_d1    <= 4'h0;
                            r_d2    <= 4'h0;
                            r_d3    <= 4'h0;
                            r_count <= 2'd0;
                            r_state <= S_ENTRY;
                        end else if (key_code == c_KEY_ENTER) begin
                            if (w_dup) begin
                                r_err <= 1'b1;
                            end else begin
                                r_num1    <= r_d1;
                                r_num2    <= r_d2;
                                r_num3    <= r_d3;
                                r_num_rdy <= 1'b1;
                                r_d1      <= 4'h0;
                                r_d2      <= 4'h0;
                                r_d3      <= 4'h0;
                                r_count   <= 2'd0;
                                r_state   <= S_EMIT;
                            end
                        end
                    end
                end

                S_EMIT: begin
                    r_state <= S_ENTRY;
                end

                default: begin
                    r_state <= S_ENTRY;
                end
            endcase
        end
    end

    assign oNum1   = r_num1;
    assign oNum2   = r_num2;
    assign oNum3   = r_num3;
    assign oNumRdy = r_num_rdy;
    assign oCount  = r_count;
    assign oEdit   = {r_d1, r_d2, r_d3};
    assign oErr    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_guess_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_guess_entry
// Description : Directed self-checking bench for guess_entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_guess_entry;

    logic        clk;
    logic        reset;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [3:0]  oNum1, oNum2, oNum3;
    logic        oNumRdy;
    logic [1:0]  oCount;
    logic [11:0] oEdit;
    logic        oErr;

    int errors;
    int checks;

    guess_entry #(
        .HOLDOFF_CYC (4),
        .MAX_DIGIT   (9)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key_code  (key_code),
        .oNum1     (oNum1),
        .oNum2     (oNum2),
        .oNum3     (oNum3),
        .oNumRdy   (oNumRdy),
        .oCount    (oCount),
        .oEdit     (oEdit),
        .oErr      (oErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe one key for one cycle; returns at the falling edge right after it was sampled.
    task automatic key(input logic [3:0] c);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle(2);
        checks++; if ({oNum1, oNum2, oNum3} !== 12'h000) begin errors++; $display("FAIL reset_num: got %h expected 000", {oNum1, oNum2, oNum3}); end
        checks++; if ({oNumRdy, oErr} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {oNumRdy, oErr}); end
        checks++; if (oCount !== 2'd0 || oEdit !== 12'h000) begin errors++; $display("FAIL reset_buf: got count=%0d edit=%h expected 0/000", oCount, oEdit); end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_commit;
        key(4'd1); checks++; if (oCount !== 2'd1) begin errors++; $display("FAIL commit_cnt1: got %0d expected 1", oCount); end
        idle(4);
        key(4'd2); idle(4);
        key(4'd3);
        checks++; if (oCount !== 2'd3 || oEdit !== 12'h123) begin errors++; $display("FAIL commit_full: got count=%0d edit=%h expected 3/123", oCount, oEdit); end
        idle(4);
        key(4'hB);
        checks++; if (oNumRdy !== 1'b1) begin errors++; $display("FAIL commit_rdy: got %b expected 1", oNumRdy); end
        checks++; if ({oNum1, oNum2, oNum3} !== 12'h123) begin errors++; $display("FAIL commit_num: got %h expected 123", {oNum1, oNum2, oNum3}); end
        checks++; if (oErr !== 1'b0) begin errors++; $display("FAIL commit_err: got %b expected 0", oErr); end
        idle(1);
        checks++; if (oNumRdy !== 1'b0) begin errors++; $display("FAIL commit_rdy_len: got %b expected 0", oNumRdy); end
        checks++; if (oCount !== 2'd0 || oEdit !== 12'h000) begin errors++; $display("FAIL commit_cleared: got count=%0d edit=%h expected 0/000", oCount, oEdit); end
        checks++; if ({oNum1, oNum2, oNum3} !== 12'h123) begin errors++; $display("FAIL commit_hold: got %h expected 123", {oNum1, oNum2, oNum3}); end
        idle(3);
    endtask

    task automatic test_backspace;
        logic [3:0]  seq  [6] = '{4'd4, 4'd5, 4'hA, 4'd7, 4'd8, 4'hA};
        logic [11:0] edt  [6] = '{12'h400, 12'h450, 12'h400, 12'h470, 12'h478, 12'h470};
        logic [1:0]  cnt  [6] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd3, 2'd2};
        for (int i = 0; i < 6; i++) begin
            key(seq[i]);
            checks++; if (oEdit !== edt[i] || oCount !== cnt[i]) begin errors++; $display("FAIL bs_step%0d: got edit=%h count=%0d expected %h/%0d", i, oEdit, oCount, edt[i], cnt[i]); end
            idle(4);
        end
        key(4'd8); idle(4);
        key(4'd9);
        checks++; if (oEdit !== 12'h478) begin errors++; $display("FAIL bs_full_ignore: got %h expected 478", oEdit); end
        idle(4);
        key(4'hB);
        checks++; if (oNumRdy !== 1'b1 || {oNum1, oNum2, oNum3} !== 12'h478) begin errors++; $display("FAIL bs_commit: got rdy=%b num=%h expected 1/478", oNumRdy, {oNum1, oNum2, oNum3}); end
        idle(4);
    endtask

    task automatic test_enter_err;
        key(4'd1); idle(4);
        key(4'd2); idle(4);
        key(4'hB);
        checks++; if (oErr !== 1'b1 || oNumRdy !== 1'b0) begin errors++; $display("FAIL err_pulse: got err=%b rdy=%b expected 1/0", oErr, oNumRdy); end
        checks++; if (oCount !== 2'd2 || oEdit !== 12'h120) begin errors++; $display("FAIL err_buf: got count=%0d edit=%h expected 2/120", oCount, oEdit); end
        idle(1);
        checks++; if (oErr !== 1'b0) begin errors++; $display("FAIL err_len: got %b expected 0", oErr); end
        checks++; if ({oNum1, oNum2, oNum3} !== 12'h478) begin errors++; $display("FAIL err_num_hold: got %h expected 478", {oNum1, oNum2, oNum3}); end
        idle(3);
        key(4'd9); idle(4);
        key(4'hC);
        checks++; if (oCount !== 2'd0 || oEdit !== 12'h000) begin errors++; $display("FAIL err_clear: got count=%0d edit=%h expected 0/000", oCount, oEdit); end
        idle(4);
        key(4'hA);
        checks++; if (oCount !== 2'd0 || oEdit !== 12'h000) begin errors++; $display("FAIL bs_empty: got count=%0d edit=%h expected 0/000", oCount, oEdit); end
        idle(4);
    endtask

    task automatic test_holdoff;
        key(4'd3);
        key(4'd5);
        checks++; if (oCount !== 2'd1 || oEdit !== 12'h300) begin errors++; $display("FAIL holdoff_drop: got count=%0d edit=%h expected 1/300", oCount, oEdit); end
        idle(4);
        key(4'hC); idle(4);
    endtask

    task automatic test_dup;
        key(4'd5); idle(4);
        key(4'd5); idle(4);
        key(4'd6); idle(4);
        key(4'hB);
`ifdef GUESS_UNIQUE_CHECK_EN
        checks++; if (oErr !== 1'b1 || oNumRdy !== 1'b0) begin errors++; $display("FAIL dup_reject: got err=%b rdy=%b expected 1/0", oErr, oNumRdy); end
        checks++; if (oCount !== 2'd3 || oEdit !== 12'h556) begin errors++; $display("FAIL dup_keep: got count=%0d edit=%h expected 3/556", oCount, oEdit); end
`else
        checks++; if (oNumRdy !== 1'b1 || oErr !== 1'b0) begin errors++; $display("FAIL dup_commit: got rdy=%b err=%b expected 1/0", oNumRdy, oErr); end
        checks++; if ({oNum1, oNum2, oNum3} !== 12'h556) begin errors++; $display("FAIL dup_num: got %h expected 556", {oNum1, oNum2, oNum3}); end
`endif
        idle(4);
        key(4'hC); idle(4);
    endtask

    task automatic test_reset_mid;
        int rdy_seen;
        key(4'd1); idle(4);
        key(4'd2); idle(4);
        key(4'd3); idle(4);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'hB;
        #2 reset = 1'b1;
        #1;
        checks++; if ({oNum1, oNum2, oNum3, oNumRdy, oErr, oCount, oEdit} !== 30'h0) begin errors++; $display("FAIL reset_async: got num=%h rdy=%b err=%b count=%0d edit=%h expected all 0", {oNum1, oNum2, oNum3}, oNumRdy, oErr, oCount, oEdit); end
        key_valid = 1'b0;
        key_code  = 4'h0;
        idle(2);
        reset = 1'b0;
        rdy_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (oNumRdy === 1'b1) rdy_seen++;
        end
        checks++; if (rdy_seen !== 0) begin errors++; $display("FAIL reset_no_rdy: got %0d pulses expected 0", rdy_seen); end
        checks++; if (oCount !== 2'd0 || oEdit !== 12'h000) begin errors++; $display("FAIL reset_post_buf: got count=%0d edit=%h expected 0/000", oCount, oEdit); end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        test_reset();
        test_commit();
        test_backspace();
        test_enter_err();
        test_holdoff();
        test_dup();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
